// File: rtl/dac_sched_pkg.sv
// Shared types, frame layout and arbitration helpers for the DAC scheduler.
package dac_sched_pkg;

  typedef enum logic [1:0] {
    S_CLR   = 2'd0,
    S_IDLE  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam int N_REQ    = 4;
  localparam int SAMPLE_W = 12;
  localparam int FRAME_W  = 32;
  localparam int DATA_LSB = 16;
  localparam int ADDR_LSB = 12;
  localparam int CMD_LSB  = 8;

  // First requester with valid set, searching upward from ptr and wrapping.
  function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] valid, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (valid[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [FRAME_W-1:0] build_frame(input logic [SAMPLE_W-1:0] data,
                                                     input logic [1:0] ch,
                                                     input logic [3:0] cmd);
    build_frame = '0;
    build_frame[DATA_LSB +: SAMPLE_W] = data;
    build_frame[ADDR_LSB +: 4]        = {2'b00, ch};
    build_frame[CMD_LSB +: 4]         = cmd;
  endfunction

endpackage

// File: rtl/dac_scheduler_if.sv
// Sample request bus between the waveform generators and the DAC scheduler.
interface dac_scheduler_if;
  import dac_sched_pkg::*;

  // Requester i offers req_data[12*i +: 12] while req_valid[i] is high and must hold both
  // until req_ready[i]; a sample transfers on a rising edge where valid & ready are both 1.
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*SAMPLE_W-1:0] req_data;
  logic [N_REQ-1:0]          req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/dac_spi_tx.sv
// 32-bit MSB-first SPI serializer: sck divider, bit counter, shift register and chip select.
module dac_spi_tx
  import dac_sched_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               spi_sck,
  output logic               spi_mosi,
  output logic               dac_cs,
  output logic               done,
  output logic               ending
);
  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic               active;
  logic [DW-1:0]      div_cnt;
  logic [4:0]         bit_cnt;
  logic [FRAME_W-1:0] shreg;
  logic               half_end;

  assign half_end = active && (div_cnt == DIV_LAST);
  // True on the edge that closes the high half of bit 0; the frame ends there.
  assign ending   = half_end && spi_sck && (bit_cnt == 5'd31);

  always_ff @(posedge clk) begin
    if (!rst) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      dac_cs   <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !active) begin
        active   <= 1'b1;
        div_cnt  <= '0;
        bit_cnt  <= '0;
        spi_sck  <= 1'b0;
        dac_cs   <= 1'b0;
        spi_mosi <= frame[FRAME_W-1];
        shreg    <= {frame[FRAME_W-2:0], 1'b0};
      end else if (active) begin
        if (!half_end) begin
          div_cnt <= div_cnt + 1'b1;
        end else begin
          div_cnt <= '0;
          if (!spi_sck) begin
            spi_sck <= 1'b1;
          end else if (ending) begin
            active   <= 1'b0;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            dac_cs   <= 1'b1;
            done     <= 1'b1;
          end else begin
            spi_sck  <= 1'b0;
            spi_mosi <= shreg[FRAME_W-1];
            shreg    <= {shreg[FRAME_W-2:0], 1'b0};
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/dac_scheduler.sv
// Round-robin sharing of one serial DAC between four requesters, with dac_clr power-up sequencing.
module dac_scheduler
  import dac_sched_pkg::*;
#(
  parameter int         CLK_DIV    = 2,
  parameter int         GAP_CYCLES = 2,
  parameter int         CLR_CYCLES = 4,
  parameter logic [3:0] COMMAND    = 4'b0011
) (
  input  logic            clk,
  input  logic            rst,
  dac_scheduler_if.slave  req,
  output logic            spi_sck,
  output logic            spi_mosi,
  output logic            dac_cs,
  output logic            dac_clr,
  output logic            busy,
  output logic            frame_done,
  output logic [1:0]      last_ch,
  output state_t          state_dbg
);
  state_t                state;
  logic [1:0]            rr_ptr;
  logic [1:0]            cur_ch;
  logic [1:0]            grant;
  logic [15:0]           cnt;
  logic                  start;
  logic                  tx_ending;
  logic [SAMPLE_W-1:0]   grant_data;

  assign grant      = rr_pick(req.req_valid, rr_ptr);
  assign start      = (state == S_IDLE) && (|req.req_valid);
  assign grant_data = req.req_data[int'(grant)*SAMPLE_W +: SAMPLE_W];
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;

  // Accept strobe is combinational so the grant and the data latch share one IDLE cycle.
  always_comb begin
    req.req_ready = '0;
    if (start) req.req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_CLR;
      rr_ptr  <= 2'd0;
      cur_ch  <= 2'd0;
      last_ch <= 2'd0;
      dac_clr <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_CLR: begin
          if (cnt == 16'(CLR_CYCLES - 1)) begin
            dac_clr <= 1'b1;
            cnt     <= '0;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_IDLE: begin
          if (start) begin
            cur_ch <= grant;
            rr_ptr <= grant + 2'd1;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (tx_ending) begin
            last_ch <= cur_ch;
            cnt     <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt == 16'(GAP_CYCLES - 1)) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_CLR;
      endcase
    end
  end

  dac_spi_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .frame    (build_frame(grant_data, grant, COMMAND)),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .dac_cs   (dac_cs),
    .done     (frame_done),
    .ending   (tx_ending)
  );

endmodule

// File: tb/tb_dac_scheduler.sv
// Bench for dac_scheduler: requester driver, SPI-decoding scoreboard and directed scenarios.
module tb_dac_scheduler;
  import dac_sched_pkg::*;

  localparam int         CLK_DIV   = 2;
  localparam int         GAP       = 2;
  localparam int         CLR       = 4;
  localparam logic [3:0] CMD       = 4'b0011;
  localparam int         FRAME_CYC = 64 * CLK_DIV;
  localparam int         PERIOD    = 1 + FRAME_CYC + GAP;

  typedef struct {
    int          ch;
    logic [11:0] d;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_sck, spi_mosi, dac_cs, dac_clr, busy, frame_done;
  logic [1:0]  last_ch;
  state_t      state_dbg;

  dac_scheduler_if rq();

  dac_scheduler #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP), .CLR_CYCLES(CLR), .COMMAND(CMD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (rq),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .dac_cs     (dac_cs),
    .dac_clr    (dac_clr),
    .busy       (busy),
    .frame_done (frame_done),
    .last_ch    (last_ch),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- shared state ----------------
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] exp_q[$];
  int          grant_log[$];
  int          rise_t[$];
  cmd_t        cmd_q[$];
  logic [3:0]  hold = 4'b0;
  logic [11:0] hold_data[4];
  bit          rand_mode = 1'b0;
  int          frames = 0;
  int          nbits = 0;
  logic [31:0] last_frame = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // ---------------- requester driver ----------------
  initial begin
    logic [3:0]  vld;
    logic [11:0] dat[4];
    logic [3:0]  hs;
    vld = '0;
    for (int i = 0; i < 4; i++) dat[i] = '0;
    rq.req_valid = '0;
    rq.req_data  = '0;
    forever begin
      @(negedge clk);
      hs = rst ? (rq.req_valid & rq.req_ready) : 4'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (!rst) vld[i] = 1'b0;
        else if (hs[i] && !hold[i]) vld[i] = 1'b0;
        else if (vld[i] && !hs[i] && !hold[i] && rand_mode && $urandom_range(0, 199) == 0)
          vld[i] = 1'b0;
        if (rst && hold[i] && !vld[i]) begin
          vld[i] = 1'b1;
          dat[i] = hold_data[i];
        end
      end
      while (rst && cmd_q.size() > 0 && !vld[cmd_q[0].ch]) begin
        cmd_t c;
        c = cmd_q.pop_front();
        vld[c.ch] = 1'b1;
        dat[c.ch] = c.d;
      end
      for (int i = 0; i < 4; i++) begin
        if (rst && rand_mode && !vld[i] && $urandom_range(0, 7) == 0) begin
          vld[i] = 1'b1;
          dat[i] = 12'($urandom);
        end
      end
      rq.req_valid = vld;
      rq.req_data  = {dat[3], dat[2], dat[1], dat[0]};
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int          since, model_ptr, low_len, g;
    logic [31:0] shreg_m, ef;
    logic        prev_cs, prev_sck, prev_mosi, model_idle, rise;
    logic [3:0]  v, exp_rdy;
    since = GAP + 1; model_ptr = 0; low_len = 0; shreg_m = '0;
    prev_cs = 1'b1; prev_sck = 1'b0; prev_mosi = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        exp_q.delete(); grant_log.delete(); rise_t.delete();
        frames = 0; nbits = 0; low_len = 0; shreg_m = '0;
        since = GAP + 1; model_ptr = 0;
        prev_cs = 1'b1; prev_sck = 1'b0; prev_mosi = 1'b0;
      end else begin
        rise = dac_cs && !prev_cs;
        if (dac_cs) since = rise ? 1 : ((since < 1000) ? since + 1 : since);
        model_idle = dac_clr && dac_cs && (since >= GAP + 1);

        // grant prediction from the round-robin rule
        v = rq.req_valid;
        exp_rdy = '0;
        g = -1;
        if (model_idle && v != 0) begin
          g = pick(v, model_ptr);
          exp_rdy = 4'b1 << g;
        end
        chk("req_ready", rq.req_ready, exp_rdy);
        chk("busy", busy, !model_idle);
        if (g >= 0) begin
          exp_q.push_back((32'(rq.req_data[12*g +: 12]) << 16) | (32'(g) << 12) | (32'(CMD) << 8));
          grant_log.push_back(g);
          model_ptr = (g + 1) % 4;
        end

        // SPI decode
        if (!dac_cs) begin
          low_len++;
          if (spi_sck && !prev_sck) begin
            shreg_m = {shreg_m[30:0], spi_mosi};
            nbits++;
          end
          if (!prev_cs && !(prev_sck && !spi_sck)) chk("mosi_stable", spi_mosi, prev_mosi);
        end else begin
          chk("idle_pins_sck_mosi", {spi_sck, spi_mosi}, 2'b00);
        end
        chk("frame_done", frame_done, rise);
        if (rise) begin
          chk("sck_rises", nbits, 32);
          chk("cs_low_len", low_len, FRAME_CYC);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL frame_unexpected: got %0h expected none (cycle %0d)", shreg_m, cyc);
          end else begin
            ef = exp_q.pop_front();
            chk("frame", shreg_m, ef);
            chk("last_ch", last_ch, ef[13:12]);
          end
          last_frame = shreg_m;
          frames++;
          rise_t.push_back(cyc);
          nbits = 0; low_len = 0; shreg_m = '0;
        end
        prev_cs = dac_cs; prev_sck = spi_sck; prev_mosi = spi_mosi;
      end
    end
  end

  // ---------------- test tasks ----------------
  task automatic do_reset();
    int n;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_cs", dac_cs, 1'b1);
    chk("rst_sck", spi_sck, 1'b0);
    chk("rst_mosi", spi_mosi, 1'b0);
    chk("rst_clr", dac_clr, 1'b0);
    chk("rst_ready", rq.req_ready, 4'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_last_ch", last_ch, 2'd0);
    chk("rst_state", state_dbg, S_CLR);
    @(posedge clk); #1 rst = 1'b1;
    n = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (dac_clr) break;
      n++;
    end
    chk("clr_low_cycles", n, CLR);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (frames < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk("wait_frames", frames >= n, 1'b1);
  endtask

  task automatic push_cmd(input int ch, input logic [11:0] d);
    cmd_t c;
    c.ch = ch;
    c.d  = d;
    cmd_q.push_back(c);
  endtask

  task automatic chk_grants(input int n, input int a, input int b, input int c, input int d, input int e);
    int want[5];
    want = '{a, b, c, d, e};
    chk("grant_count", grant_log.size() >= n, 1'b1);
    if (grant_log.size() >= n)
      for (int k = 0; k < n; k++) chk("grant_order", grant_log[k], want[k]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    for (int i = 0; i < 4; i++) hold_data[i] = '0;

    // reset and power-up clear, then idle with no requests
    do_reset();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("idle_cs", dac_cs, 1'b1);
    chk("idle_sck", spi_sck, 1'b0);
    chk("idle_ready", rq.req_ready, 4'b0);
    chk("idle_busy", busy, 1'b0);

    // single request on channel 2
    push_cmd(2, 12'hABC);
    wait_frames(1, 400);
    chk("ch2_frame", last_frame, 32'h0ABC_2300);
    chk("ch2_last_ch", last_ch, 2'd2);
    chk_grants(1, 2, 0, 0, 0, 0);

    // all four requesters held valid from reset
    do_reset();
    for (int i = 0; i < 4; i++) hold_data[i] = 12'(12'h100 * i);
    hold = 4'b1111;
    wait_frames(5, 5 * PERIOD + 100);
    hold = 4'b0000;
    chk_grants(5, 0, 1, 2, 3, 0);
    chk("rise_count", rise_t.size() >= 5, 1'b1);
    if (rise_t.size() >= 5)
      for (int k = 0; k < 4; k++) chk("cs_rise_spacing", rise_t[k+1] - rise_t[k], PERIOD);

    // request arriving mid-frame waits for the next idle slot
    do_reset();
    push_cmd(3, 12'($urandom));
    t = 0;
    while (dac_cs && t < 200) begin @(posedge clk); t++; end
    chk("ch3_started", dac_cs, 1'b0);
    repeat (30) @(posedge clk);
    push_cmd(1, 12'($urandom));
    wait_frames(2, 3 * PERIOD);
    chk_grants(2, 3, 1, 0, 0, 0);

    // pointer at 0 with channels 1 and 3 valid
    do_reset();
    push_cmd(1, 12'h111);
    push_cmd(3, 12'h333);
    wait_frames(2, 3 * PERIOD);
    chk_grants(2, 1, 3, 0, 0, 0);

    // reset in the middle of a frame
    do_reset();
    push_cmd(2, 12'h5A5);
    t = 0;
    while (nbits < 16 && t < 400) begin @(posedge clk); t++; end
    chk("mid_frame_reached", nbits >= 16, 1'b1);
    do_reset();
    push_cmd(0, 12'h00F);
    push_cmd(2, 12'hF00);
    wait_frames(2, 3 * PERIOD);
    chk_grants(2, 0, 2, 0, 0, 0);

    // randomized traffic with occasional withdrawn requests
    do_reset();
    rand_mode = 1'b1;
    wait_frames(300, 300 * (PERIOD + 20));
    rand_mode = 1'b0;
    t = 0;
    while ((rq.req_valid != 0 || !dac_cs || exp_q.size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain_valid", rq.req_valid, 4'b0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
